send_nums: RTL and testbench

SEND_NUMS -- requirements
Module: send_nums

---
 rtl/send_nums_pkg.sv | 29 ++
 rtl/send_nums_if.sv | 29 ++
 rtl/send_nums_uart_tx.sv | 114 +++++++++++
 rtl/send_nums.sv | 102 ++++++++++
 tb/tb_send_nums.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/send_nums_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : send_nums_pkg
//  Description : Shared UART frame constants and state encodings for the
//                dual-line operand transmitter and its serial peers.
//  Revision    : 1.0 - initial release
// ============================================================================
package send_nums_pkg;

    // Serial frame shape: one start bit, eight data bits LSB first, one stop bit
    localparam logic c_START_BIT = 1'b0;
    localparam logic c_STOP_BIT  = 1'b1;
    localparam int   c_DATA_BITS = 8;

    // Per-line transmitter states
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t c_TX_IDLE  = 2'd0;
    localparam tx_state_t c_TX_START = 2'd1;
    localparam tx_state_t c_TX_DATA  = 2'd2;
    localparam tx_state_t c_TX_STOP  = 2'd3;

    // Frame-pair sequencer states
    typedef logic [1:0] top_state_t;
    localparam top_state_t c_TOP_IDLE = 2'd0;
    localparam top_state_t c_TOP_SEND = 2'd1;
    localparam top_state_t c_TOP_GAP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/send_nums_if.sv
`default_nettype none
// ============================================================================
//  Module      : send_nums_if
//  Description : Operand load / send controls and the two UART lines with
//                their status flags, bundled for the send_nums block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface send_nums_if;
    logic [7:0] sw;
    logic       load_a;
    logic       load_b;
    logic       send;
    logic       auto_en;
    logic       serial1;
    logic       serial2;
    logic       busy;
    logic       done;

    modport master (
        output sw, load_a, load_b, send, auto_en,
        input  serial1, serial2, busy, done
    );

    modport slave (
        input  sw, load_a, load_b, send, auto_en,
        output serial1, serial2, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/send_nums_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 UART transmitter. Latches data on start, drives a
//                registered line and flags the final cycle of the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       start,
    input  wire logic [7:0] data,
    output logic            tx,
    output logic            tx_done
);
    import send_nums_pkg::*;

    localparam int              c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      c_IDX_LAST = 3'(c_DATA_BITS - 1);

    tx_state_t          r_state, w_state_nx;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [2:0]         r_idx, w_idx_nx;
    logic [7:0]         r_shift, w_shift_nx;
    logic               r_tx, w_tx_nx;
    logic               w_bit_end;

    // State and datapath registers; the line is registered so it never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_TX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= c_STOP_BIT;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_tx    <= w_tx_nx;
        end
    end

    // Next-state logic: the next line level is chosen together with the state so
    // each bit boundary moves straight to the following bit with no idle cycle
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        tx_done    = 1'b0;
        w_bit_end  = (r_cnt == c_CNT_LAST);
        case (r_state)
            c_TX_IDLE: begin
                w_tx_nx = c_STOP_BIT;
                if (start) begin
                    w_state_nx = c_TX_START;
                    w_cnt_nx   = '0;
                    w_shift_nx = data;
                    w_tx_nx    = c_START_BIT;
                end
            end
            c_TX_START: begin
                if (w_bit_end) begin
                    w_state_nx = c_TX_DATA;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_tx_nx    = r_shift[0];
                    w_shift_nx = r_shift >> 1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            c_TX_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nx = c_TX_STOP;
                        w_tx_nx    = c_STOP_BIT;
                    end else begin
                        w_idx_nx   = r_idx + 1'b1;
                        w_tx_nx    = r_shift[0];
                        w_shift_nx = r_shift >> 1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            c_TX_STOP: begin
                if (w_bit_end) begin
                    w_state_nx = c_TX_IDLE;
                    w_cnt_nx   = '0;
                    w_tx_nx    = c_STOP_BIT;
                    tx_done    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = c_TX_IDLE;
                w_tx_nx    = c_STOP_BIT;
            end
        endcase
    end

    assign tx = r_tx;

endmodule
`default_nettype wire

// File: rtl/send_nums.sv
`default_nettype none
// ============================================================================
//  Module      : send_nums
//  Description : Holds two switch-loaded operands and transmits them as a
//                lockstep pair of UART frames, on demand or periodically.
//  Revision    : 1.0 - initial release
// ============================================================================
module send_nums #(
    parameter int CLKS_PER_BIT  = 5208,
    parameter int REPEAT_CYCLES = 2500000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    send_nums_if.slave bus
);
    import send_nums_pkg::*;

    localparam int                 c_REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);

    logic [7:0]         r_op_a, r_op_b;
    logic [c_REP_W-1:0] r_rep;
    top_state_t         r_state, w_state_nx;
    logic               w_go, w_busy, w_done;
    logic               w_tx1, w_tx2, w_txd1, w_txd2;

    // Operand capture; accepted in every state, the transmitters hold their own copy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else begin
            if (bus.load_a) r_op_a <= bus.sw;
            if (bus.load_b) r_op_b <= bus.sw;
        end
    end

    // Repeat timer: runs only while idle with auto enabled, restarts after each pair
    always_ff @(posedge clk) begin
        if (rst || (r_state == c_TOP_GAP) || !bus.auto_en) begin
            r_rep <= '0;
        end else if ((r_state == c_TOP_IDLE) && (r_rep != c_REP_LAST)) begin
            r_rep <= r_rep + 1'b1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_TOP_IDLE;
        else     r_state <= w_state_nx;
    end

    // Sequencer next state and status; a go pulse both leaves IDLE and makes both
    // transmitters latch the current operands, so a same-cycle load lands next frame
    always_comb begin
        w_state_nx = r_state;
        w_go       = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            c_TOP_IDLE: begin
                w_go = bus.send || (bus.auto_en && (r_rep == c_REP_LAST));
                if (w_go) w_state_nx = c_TOP_SEND;
            end
            c_TOP_SEND: begin
                w_busy = 1'b1;
                if (w_txd1 && w_txd2) w_state_nx = c_TOP_GAP;
            end
            c_TOP_GAP: begin
                w_busy     = 1'b1;
                w_done     = 1'b1;
                w_state_nx = c_TOP_IDLE;
            end
            default: w_state_nx = c_TOP_IDLE;
        endcase
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_a (
        .clk     (clk),
        .rst     (rst),
        .start   (w_go),
        .data    (r_op_a),
        .tx      (w_tx1),
        .tx_done (w_txd1)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_b (
        .clk     (clk),
        .rst     (rst),
        .start   (w_go),
        .data    (r_op_b),
        .tx      (w_tx2),
        .tx_done (w_txd2)
    );

    assign bus.serial1 = w_tx1;
    assign bus.serial2 = w_tx2;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_send_nums.sv
`default_nettype none
// ============================================================================
//  Module      : tb_send_nums
//  Description : Self-checking bench for send_nums with a frame-level model
//                of the operands and the expected line waveforms.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_send_nums;
    localparam int CPB   = 4;
    localparam int REP   = 20;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    send_nums_if bus();

    send_nums #(.CLKS_PER_BIT(CPB), .REPEAT_CYCLES(REP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_a, model_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line waveform of one frame, one entry per clock, first entry = first start-bit cycle
    function automatic logic [FRAME-1:0] exp_wave(input logic [7:0] b);
        logic [9:0]       fr;
        logic [FRAME-1:0] w;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < FRAME; i++) w[i] = fr[i / CPB];
        return w;
    endfunction

    task automatic load(input bit la, input bit lb, input logic [7:0] v);
        bus.sw = v; bus.load_a = la; bus.load_b = lb;
        if (la) model_a = v;
        if (lb) model_b = v;
        @(negedge clk);
        bus.load_a = 1'b0; bus.load_b = 1'b0;
    endtask

    task automatic send_frame(input string tag, input bit la, input bit lb,
                              input logic [7:0] v, input bit mid_send);
        logic [7:0]       ea, eb;
        logic [FRAME-1:0] o1, o2;
        bit               busy_ok, done_early, late;
        ea = model_a; eb = model_b;
        bus.sw = v; bus.load_a = la; bus.load_b = lb; bus.send = 1'b1;
        if (la) model_a = v;
        if (lb) model_b = v;
        @(negedge clk);
        bus.load_a = 1'b0; bus.load_b = 1'b0; bus.send = 1'b0;
        busy_ok = 1'b1; done_early = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            o1[i] = bus.serial1;
            o2[i] = bus.serial2;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done !== 1'b0) done_early = 1'b1;
            if (mid_send) bus.send = (i == 9);
            @(negedge clk);
        end
        bus.send = 1'b0;
        chk($sformatf("%s_serial1", tag), 64'(o1), 64'(exp_wave(ea)));
        chk($sformatf("%s_serial2", tag), 64'(o2), 64'(exp_wave(eb)));
        chk($sformatf("%s_busy_in_frame", tag), 64'(busy_ok), 64'd1);
        chk($sformatf("%s_done_early", tag), 64'(done_early), 64'd0);
        chk($sformatf("%s_done_pulse", tag), 64'({bus.done, bus.busy}), 64'b11);
        @(negedge clk);
        late = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
                bus.serial1 !== 1'b1 || bus.serial2 !== 1'b1) late = 1'b1;
            @(negedge clk);
        end
        chk($sformatf("%s_after_done_idle", tag), 64'(late), 64'd0);
    endtask

    task automatic wait_busy_rise(output int n, output bit ok);
        logic prev;
        prev = bus.busy;
        n  = 0;
        ok = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!prev && bus.busy) begin
                n  = k;
                ok = 1'b1;
                break;
            end
            prev = bus.busy;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        bit         ok, flag;
        logic [7:0] v1, v2;
        int         mode;

        bus.sw = '0; bus.load_a = 1'b0; bus.load_b = 1'b0;
        bus.send = 1'b0; bus.auto_en = 1'b0;
        model_a = '0; model_b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_lines", 64'({bus.serial1, bus.serial2}), 64'b11);
        chk("reset_flags", 64'({bus.busy, bus.done}), 64'b00);
        rst = 1'b0;

        // Quiet period: lines idle high, never busy
        flag = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.serial1 !== 1'b1 || bus.serial2 !== 1'b1 || bus.busy !== 1'b0) flag = 1'b1;
        end
        chk("idle_100", 64'(flag), 64'd0);

        // Basic pair of frames
        load(1'b1, 1'b0, 8'hA5);
        load(1'b0, 1'b1, 8'h3C);
        send_frame("basic", 1'b0, 1'b0, 8'h00, 1'b0);

        // A second send mid-frame is dropped
        send_frame("resend_ignored", 1'b0, 1'b0, 8'h00, 1'b1);

        // Load and send together: old value now, new value next frame
        load(1'b1, 1'b0, 8'h55);
        send_frame("load_with_send", 1'b1, 1'b0, 8'h0F, 1'b0);
        send_frame("after_load_send", 1'b0, 1'b0, 8'h00, 1'b0);

        // Both operands captured in one cycle
        load(1'b1, 1'b1, 8'hC3);
        send_frame("dual_load", 1'b0, 1'b0, 8'h00, 1'b0);

        // Randomised operand traffic
        for (int r = 0; r < 4; r++) begin
            v1   = 8'($urandom);
            v2   = 8'($urandom);
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                load(1'b1, 1'b0, v1);
                load(1'b0, 1'b1, v2);
                send_frame($sformatf("rand%0d", r), 1'b0, 1'b0, 8'h00, 1'b0);
            end else if (mode == 1) begin
                load(1'b1, 1'b1, v1);
                send_frame($sformatf("rand%0d", r), 1'b0, 1'b0, 8'h00, 1'b0);
            end else begin
                load(1'b1, 1'b0, v1);
                send_frame($sformatf("rand%0d", r), 1'b0, 1'b1, v2, 1'b0);
            end
        end

        // Reset during a frame aborts it and clears the operands
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_lines", 64'({bus.serial1, bus.serial2}), 64'b11);
        chk("midrst_flags", 64'({bus.busy, bus.done}), 64'b00);
        model_a = '0; model_b = '0;
        flag = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
                bus.serial1 !== 1'b1 || bus.serial2 !== 1'b1) flag = 1'b1;
        end
        chk("midrst_quiet", 64'(flag), 64'd0);
        send_frame("post_rst", 1'b0, 1'b0, 8'h00, 1'b0);

        // Periodic mode: 20 idle cycles before the first frame, then 40+1+20 period
        load(1'b1, 1'b1, 8'h81);
        bus.auto_en = 1'b1;
        wait_busy_rise(n, ok);
        chk("auto_first_seen", 64'(ok), 64'd1);
        chk("auto_first_delay", 64'(n), 64'd20);
        chk("auto_start_lockstep", 64'({bus.serial1, bus.serial2}), 64'b00);
        wait_busy_rise(n, ok);
        chk("auto_period1", 64'(n), 64'd61);
        wait_busy_rise(n, ok);
        chk("auto_period2", 64'(n), 64'd61);

        // Drop auto during the gap cycle: no further frames
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("auto_done_seen", 64'(ok), 64'd1);
        bus.auto_en = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.serial1 !== 1'b1) flag = 1'b1;
        end
        chk("auto_stopped", 64'(flag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
